// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the ALU-downstream sequencer: FSM states, default
// widths and the PC source selection used by the decoder.
package pc_branch_ctrl_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Next-PC source chosen by the control FSM each cycle.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_LOAD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_INC    = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_branch_ctrl_branch_lut.sv
// Branch target table: register file with one synchronous write port and one
// combinational read port; a same-cycle write is seen from the next cycle.
module branch_lut
  import pc_branch_ctrl_pkg::*;
#(
  parameter int IDX_W  = LUT_IDX_W_DEF,
  parameter int DATA_W = PC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // NOTE: the table is small and must read as zero after reset, so every
  // entry is a resettable flop rather than an inferred RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter sequencer: registers ALU flag/carry, resolves branches
// through branch_lut and runs the IDLE/RUN/HALT control FSM.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  input  logic                 cnd_i,
  input  logic                 cnd_we,
  input  logic                 sc_i,
  input  logic                 sc_we,
  input  logic                 sc_clr,
  input  logic                 br_cond,
  input  logic                 br_uncond,
  input  logic [LUT_IDX_W-1:0] br_idx,
  input  logic                 halt_i,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc_o,
  output logic                 flag_o,
  output logic                 sc_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  state_e           state_q, state_d;
  pc_sel_e          pc_sel;
  logic             cnt_clr, cnt_en;
  logic [PC_W-1:0]  pc_q, br_target;
  logic             flag_q, sc_q;
  logic [CNT_W-1:0] cnt_q;

  branch_lut #(
    .IDX_W  (LUT_IDX_W),
    .DATA_W (PC_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (br_idx),
    .rdata (br_target)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_sel  = PC_LOAD;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (start) begin
          pc_sel  = PC_LOAD;
          cnt_clr = 1'b1;
        end else begin
          // The HALT cycle itself still counts as a run cycle.
          cnt_en = 1'b1;
          if (halt_i)                           state_d = ST_HALT;
          else if (br_uncond || (br_cond && flag_q)) pc_sel = PC_BRANCH;
          else                                  pc_sel  = PC_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; br_cond therefore always sees the old flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      case (pc_sel)
        PC_LOAD:   pc_q <= start_addr;
        PC_BRANCH: pc_q <= br_target;
        PC_INC:    pc_q <= pc_q + PC_W'(1);
        default:   pc_q <= pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Flag and carry follow the ALU only while a program is executing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= 1'b0;
      sc_q   <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (cnd_we) flag_q <= cnd_i;
      if (sc_clr)     sc_q <= 1'b0;
      else if (sc_we) sc_q <= sc_i;
    end
  end

  assign pc_o        = pc_q;
  assign flag_o      = flag_q;
  assign sc_o        = sc_q;
  assign running_o   = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_HALT);
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: a behavioural model predicts outputs
// after each edge; a monitor pops and compares them. A CNT_W=4 copy shares stimulus.
module tb_pc_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic       cnd_i, cnd_we, sc_i, sc_we, sc_clr;
  logic       br_cond, br_uncond;
  logic [3:0] br_idx;
  logic       halt_i;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [9:0] lut_wdata;

  logic [9:0]  pc_o, pc_s;
  logic        flag_o, sc_o, running_o, done_o;
  logic        flag_s, sc_s, running_s, done_s;
  logic [15:0] cnt_o;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  pc_branch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .cnd_i(cnd_i), .cnd_we(cnd_we), .sc_i(sc_i), .sc_we(sc_we), .sc_clr(sc_clr),
    .br_cond(br_cond), .br_uncond(br_uncond), .br_idx(br_idx), .halt_i(halt_i),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_o(pc_o), .flag_o(flag_o), .sc_o(sc_o), .running_o(running_o),
    .done_o(done_o), .cycle_cnt_o(cnt_o)
  );

  pc_branch_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .cnd_i(cnd_i), .cnd_we(cnd_we), .sc_i(sc_i), .sc_we(sc_we), .sc_clr(sc_clr),
    .br_cond(br_cond), .br_uncond(br_uncond), .br_idx(br_idx), .halt_i(halt_i),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_o(pc_s), .flag_o(flag_s), .sc_o(sc_s), .running_o(running_s),
    .done_o(done_s), .cycle_cnt_o(cnt_s)
  );

  typedef struct {
    int pc;
    int flag;
    int sc;
    int running;
    int done;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  int m_pc, m_flag, m_sc, m_cnt;
  bit m_running, m_halted;
  int m_lut[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_flag = 0; m_sc = 0; m_cnt = 0;
    m_running = 0; m_halted = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic clear_inputs();
    start = 0; start_addr = '0; cnd_i = 0; cnd_we = 0; sc_i = 0; sc_we = 0;
    sc_clr = 0; br_cond = 0; br_uncond = 0; br_idx = '0; halt_i = 0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  // Apply one clock of the current inputs to the model, then to the DUT.
  task automatic step();
    exp_t e;
    int   target;
    bit   was_running;
    target      = m_lut[br_idx];
    was_running = m_running;
    if (start) begin
      m_running = 1; m_halted = 0; m_pc = int'(start_addr); m_cnt = 0;
    end else if (was_running) begin
      m_cnt++;
      if (halt_i) begin
        m_running = 0; m_halted = 1;
      end else if (br_uncond || (br_cond && m_flag == 1)) begin
        m_pc = target;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    if (was_running) begin
      if (cnd_we) m_flag = int'(cnd_i);
      if (sc_clr) m_sc = 0;
      else if (sc_we) m_sc = int'(sc_i);
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    e.pc = m_pc; e.flag = m_flag; e.sc = m_sc;
    e.running = int'(m_running); e.done = int'(m_halted); e.cnt = m_cnt;
    @(posedge clk);
    exp_q.push_back(e);
    #4;
    clear_inputs();
  endtask

  // Monitor: outputs are registered, so each edge presents one new response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",      32'(pc_o),      32'(e.pc));
        check("flag",    32'(flag_o),    32'(e.flag));
        check("sc",      32'(sc_o),      32'(e.sc));
        check("running", 32'(running_o), 32'(e.running));
        check("done",    32'(done_o),    32'(e.done));
        check("cnt",     32'(cnt_o),     32'(clamp(e.cnt, 65535)));
        check("pc_s",    32'(pc_s),      32'(e.pc));
        check("cnt_s",   32'(cnt_s),     32'(clamp(e.cnt, 15)));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},      32'(pc_o),      32'd0);
    check({tag, "_flag"},    32'(flag_o),    32'd0);
    check({tag, "_sc"},      32'(sc_o),      32'd0);
    check({tag, "_running"}, 32'(running_o), 32'd0);
    check({tag, "_done"},    32'(done_o),    32'd0);
    check({tag, "_cnt"},     32'(cnt_o),     32'd0);
    check({tag, "_cnt_s"},   32'(cnt_s),     32'd0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 0;
    #1 reset = 1;
    #2 check_all_zero("reset");
    #9 reset = 0;

    // Straight-line run from 0x010.
    start = 1; start_addr = 10'h010; step();
    repeat (5) step();

    // Flag registered one cycle before br_cond -> branch taken.
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h2A0; step();
    cnd_we = 1; cnd_i = 1; step();
    br_cond = 1; br_idx = 4'd3; step();
    // Old flag 0 decides even though a 1 is latched in the same cycle.
    cnd_we = 1; cnd_i = 0; step();
    cnd_we = 1; cnd_i = 1; br_cond = 1; br_idx = 4'd3; step();
    step();

    // PC wrap at the top of memory.
    start = 1; start_addr = 10'h3FF; step();
    step(); step();

    // Carry set, then clear wins over a simultaneous write.
    sc_we = 1; sc_i = 1; step();
    sc_we = 1; sc_i = 1; sc_clr = 1; step();

    // Halt holds the PC and freezes the counter, start resumes.
    start = 1; start_addr = 10'h020; step();
    halt_i = 1; step();
    br_uncond = 1; br_idx = 4'd3; cnd_we = 1; cnd_i = 0; step();
    step(); step();
    start = 1; start_addr = 10'h000; step();
    step();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      if (!m_running) begin
        start = ($urandom_range(0, 3) == 0);
      end else begin
        start  = ($urandom_range(0, 99) == 0);
        halt_i = ($urandom_range(0, 49) == 0);
      end
      start_addr = 10'($urandom);
      cnd_we     = ($urandom_range(0, 2) == 0);
      cnd_i      = 1'($urandom);
      sc_we      = ($urandom_range(0, 2) == 0);
      sc_i       = 1'($urandom);
      sc_clr     = ($urandom_range(0, 5) == 0);
      br_uncond  = ($urandom_range(0, 7) == 0);
      br_cond    = ($urandom_range(0, 3) == 0);
      br_idx     = 4'($urandom);
      lut_we     = ($urandom_range(0, 3) == 0);
      lut_waddr  = 4'($urandom);
      lut_wdata  = 10'($urandom);
      step();
    end

    // Asynchronous reset between edges while running.
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h2A0;
    start = 1; start_addr = 10'h100; step();
    step(); step();
    reset = 1;
    #1 check_all_zero("async_rst");
    model_reset();
    #2 reset = 0;
    #1;
    start = 1; start_addr = 10'h155; step();
    br_uncond = 1; br_idx = 4'd3; step();
    repeat (20) step();

    #6;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Sequencer stage directly downstream of the 8-bit ALU. It consumes the ALU's cnd and sc_o outputs and produces the program counter that drives instruction fetch.
- Registers the condition flag and shift-carry. The registered carry is fed back to the ALU's sc_i.
- Resolves conditional and unconditional branches through a small target lookup table.
- Runs an IDLE/RUN/HALT control FSM with a run-cycle counter used for program timing.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- LUT_IDX_W, 4, branch target LUT index width; the LUT has 2^LUT_IDX_W entries of PC_W bits.
- CNT_W, 16, run-cycle counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; loads start_addr and enters RUN.
- start_addr  in  PC_W  program entry address.
- cnd_i  in  1  ALU condition result (CMP/CEQ).
- cnd_we  in  1  latch cnd_i into the flag register this cycle.
- sc_i  in  1  ALU shift/carry out.
- sc_we  in  1  latch sc_i into the carry register this cycle.
- sc_clr  in  1  clear the carry register; wins over sc_we.
- br_cond  in  1  branch to LUT[br_idx] if the registered flag is 1.
- br_uncond  in  1  branch to LUT[br_idx] unconditionally.
- br_idx  in  LUT_IDX_W  branch target LUT index.
- halt_i  in  1  HALT instruction decoded.
- lut_we  in  1  LUT write enable; accepted in any state.
- lut_waddr  in  LUT_IDX_W  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- pc_o  out  PC_W  current fetch address.
- flag_o  out  1  registered condition flag.
- sc_o  out  1  registered carry; drives the ALU sc_i.
- running_o  out  1  high while the FSM is in RUN.
- done_o  out  1  high while the FSM is in HALT.
- cycle_cnt_o  out  CNT_W  number of cycles spent in RUN since the last start.

Behaviour:
- Reset (asynchronous, any state):
  - pc_o=0, flag_o=0, sc_o=0, cycle_cnt_o=0.
  - FSM goes to IDLE; running_o=0, done_o=0.
  - All LUT entries become 0.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start. pc<=start_addr and cycle_cnt<=0 in the same edge.
  - RUN -> HALT on halt_i. The PC holds at the HALT instruction's address and the counter stops.
  - HALT -> RUN on start, with the same loads as from IDLE. Otherwise HALT persists and done_o stays high.
  - start during RUN restarts the program: pc<=start_addr and cycle_cnt<=0. start has priority over halt_i and over branches.
- PC update in RUN, priority highest first:
  1. start
  2. halt_i (hold)
  3. br_uncond
  4. br_cond with flag_o=1
  5. pc+1
- The branch target is LUT[br_idx], read combinationally from the registered table.
- pc+1 at 2^PC_W-1 wraps to 0.
- In IDLE and HALT the PC holds and branch inputs are ignored.
- Latency: a branch presented in cycle N makes pc_o equal the target from cycle N+1. There are no delay slots.
- Flag timing:
  - br_cond always uses the flag value registered before the current edge.
  - If cnd_we and br_cond are asserted in the same cycle, the old flag decides the branch; the new flag is visible from the next cycle.
  - cnd_we and sc_we/sc_clr take effect only in RUN.
- Carry: sc_o updates one edge after sc_we, so a back-to-back ADD chain sees the previous carry.
- LUT write/read collision: a write to the index being read in the same cycle returns the old entry; the new entry is visible from the next cycle.
- Cycle counter:
  - Increments on every RUN cycle, including the cycle in which halt_i is asserted.
  - Saturates at 2^CNT_W-1; it does not wrap.
  - Holds in HALT; clears on start.

Decomposition:
- Shared package (alu/cpu package) holds:
  - the FSM state enum {IDLE, RUN, HALT};
  - default PC_W, LUT_IDX_W and CNT_W constants;
  - the branch-select encoding used by the decoder.
- One sub-module, branch_lut: a 2^LUT_IDX_W x PC_W register file with async reset, one synchronous write port and one combinational read port.

Test Plan:
- Reset then start with start_addr=0x010, no branches, 5 cycles -> pc_o sequence 0x010..0x015, running_o=1, cycle_cnt_o=5.
- Write LUT[3]=0x2A0; cnd_we with cnd_i=1 in cycle N; br_cond with br_idx=3 in cycle N+1 -> pc_o=0x2A0 in N+2. Repeat with cnd_i=1 latched and br_cond in the same cycle, old flag=0 -> no branch, pc+1.
- start_addr=0x3FF, run 2 cycles -> pc_o goes 0x3FF -> 0x000 -> 0x001.
- sc_we with sc_i=1, then sc_we and sc_clr together next cycle -> sc_o=1 then 0.
- halt_i at pc=0x020 -> pc_o holds 0x020, done_o=1, running_o=0, cycle_cnt_o frozen. start with start_addr=0x000 -> RUN, counter=0.
- Assert reset mid-RUN, asynchronously between edges -> all outputs 0 immediately and LUT[3] reads 0. CNT_W=4, run 20 cycles -> cycle_cnt_o saturates at 15.
